// File: rtl/dma_addr_ring_pkg.sv
// dma_addr_pkg: register map, CTRL/STATUS bit positions and the per-channel
// control record shared by the DMA address ring top level and its channels.
// Optional interrupt support is selected by the DMA_ADDR_RING_IRQ_EN macro.
package dma_addr_pkg;

  // Register offsets inside one channel's 4-word window.
  localparam logic [1:0] REG_BASE   = 2'd0;
  localparam logic [1:0] REG_STRIDE = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_NBUF_LSB   = 8;

  // STATUS bit positions (read and write views).
  localparam int STAT_RELEASE_BIT = 0;
  localparam int STAT_IDX_LSB     = 0;
  localparam int STAT_FILL_LSB    = 8;
  localparam int STAT_OVF_BIT     = 31;

  // Control fields are held at their widest legal size; only the low
  // ADDR_W / NBUF_W bits are ever written, so the rest stay zero.
  localparam int MAX_ADDR_W = 32;
  localparam int MAX_NBUF_W = 8;

  typedef struct packed {
    logic                  en;
    logic                  irq_en;
    logic [MAX_NBUF_W-1:0] nbuf_m1;
    logic [MAX_ADDR_W-1:0] base;
    logic [MAX_ADDR_W-1:0] stride;
  } ch_ctrl_t;

  // Width of the channel-select field; a single channel still gets one bit.
  function automatic int ch_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/dma_addr_ring_if.sv
// Avalon-MM slave port of the DMA address ring (software side).
interface dma_addr_ring_if #(
  parameter int NUM_CH = 2
);
  localparam int AW = $clog2(NUM_CH) + 2;

  logic [AW-1:0] avs_s0_address;
  logic          avs_s0_read;
  logic          avs_s0_write;
  logic [31:0]   avs_s0_writedata;
  logic [31:0]   avs_s0_readdata;

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    input  avs_s0_readdata
  );

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    output avs_s0_readdata
  );
endinterface

// File: rtl/dma_addr_ring_ch.sv
// dma_ring_ch: ring state of one DMA channel (current address, write index,
// fill count and overflow flag). Addresses step by STRIDE with an adder and
// snap back to BASE on wrap, so no multiplier is needed.
module dma_ring_ch
  import dma_addr_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int NBUF_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  ch_ctrl_t          ctrl_i,
  input  logic              start_i,     // EN 0->1 write this cycle
  input  logic              release_i,   // STATUS write with RELEASE set
  input  logic              ovf_clr_i,   // STATUS write with OVF W1C set
  input  logic              buf_done_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [NBUF_W-1:0] wr_idx_o,
  output logic [NBUF_W:0]   fill_o,
  output logic              ovf_o
);

  localparam logic [NBUF_W:0]   FILL_ONE = 1;
  localparam logic [NBUF_W-1:0] IDX_ONE  = 1;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NBUF_W-1:0] idx_q, idx_d;
  logic [NBUF_W:0]   fill_q, fill_d;
  logic              ovf_q, ovf_d;

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] stride;
  logic [NBUF_W-1:0] nbuf_m1;
  logic [NBUF_W:0]   depth;
  logic              full, rel_eff, done, advance, ovf_set;
  logic              unused_ctrl;

  assign base    = ctrl_i.base[ADDR_W-1:0];
  assign stride  = ctrl_i.stride[ADDR_W-1:0];
  assign nbuf_m1 = ctrl_i.nbuf_m1[NBUF_W-1:0];
  assign depth   = {1'b0, nbuf_m1} + FILL_ONE;
  // Upper control bits are always zero; fold them so they are not dangling.
  assign unused_ctrl = ^ctrl_i;

  assign full    = (fill_q >= depth);
  assign rel_eff = release_i && (fill_q != '0);
  assign done    = buf_done_i && ctrl_i.en;
  // A release landing with buf_done frees a slot, so even a full ring advances.
  assign advance = done && (!full || rel_eff);
  assign ovf_set = done && full && !rel_eff;

  // Next-state of the ring: restart on enable, otherwise advance/release/flag.
  always_comb begin
    addr_d = addr_q;
    idx_d  = idx_q;
    fill_d = fill_q;
    ovf_d  = ovf_q;
    if (start_i) begin
      addr_d = base;
      idx_d  = '0;
      fill_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (advance) begin
        if (idx_q == nbuf_m1) begin
          idx_d  = '0;
          addr_d = base;
        end else begin
          idx_d  = idx_q + IDX_ONE;
          addr_d = addr_q + stride;
        end
      end
      if (advance && !rel_eff) begin
        fill_d = fill_q + FILL_ONE;
      end else if (!advance && rel_eff) begin
        fill_d = fill_q - FILL_ONE;
      end
      // A fresh overflow wins over a simultaneous clear.
      if (ovf_set) begin
        ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
        ovf_d = 1'b0;
      end
    end
  end

  // Ring state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      idx_q  <= '0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      idx_q  <= idx_d;
      fill_q <= fill_d;
      ovf_q  <= ovf_d;
    end
  end

  assign addr_o   = addr_q;
  assign wr_idx_o = idx_q;
  assign fill_o   = fill_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/dma_addr_ring.sv
// dma_addr_ring: multi-channel DMA buffer-ring address generator on an
// Avalon-MM slave. Holds per-channel control registers, decodes the bus,
// registers read data and reduces the interrupt.
// Optional feature macro: DMA_ADDR_RING_IRQ_EN (writable IRQ_EN and a driven
// irq); without it IRQ_EN reads 0 and irq is tied low.
module dma_addr_ring
  import dma_addr_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 28,
  parameter int NBUF_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  dma_addr_ring_if.slave           avs,
  input  logic [NUM_CH-1:0]        buf_done,
  output logic [NUM_CH*ADDR_W-1:0] dma_address,
  output logic                     irq
);

  localparam int CH_W = ch_sel_w(NUM_CH);
  localparam int AW   = $clog2(NUM_CH) + 2;

  logic [1:0]      reg_sel;
  logic [CH_W-1:0] ch_sel;
  logic [31:0]     rd_base   [NUM_CH];
  logic [31:0]     rd_stride [NUM_CH];
  logic [31:0]     rd_ctrl   [NUM_CH];
  logic [31:0]     rd_status [NUM_CH];
  logic [31:0]     rd_word;
  logic [31:0]     readdata_q;
  logic            unused_wdata;
`ifdef DMA_ADDR_RING_IRQ_EN
  logic [NUM_CH-1:0] irq_src;
  logic              irq_q;
`endif

  assign reg_sel = avs.avs_s0_address[1:0];
  // Only a handful of writedata bits are decoded; fold the rest.
  assign unused_wdata = ^avs.avs_s0_writedata;

  generate
    if (NUM_CH > 1) begin : g_chsel
      assign ch_sel = avs.avs_s0_address[AW-1:2];
    end else begin : g_chsel_one
      assign ch_sel = '0;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_ctrl_t          ctrl_q;
      logic              wr_hit, start, release_p, ovf_clr;
      logic [ADDR_W-1:0] addr;
      logic [NBUF_W-1:0] wr_idx;
      logic [NBUF_W:0]   fill;
      logic              ovf;
      logic [31:0]       ctrl_word, status_word;

      assign wr_hit    = avs.avs_s0_write && (int'(ch_sel) == gi);
      assign start     = wr_hit && (reg_sel == REG_CTRL) &&
                         avs.avs_s0_writedata[CTRL_EN_BIT] && !ctrl_q.en;
      assign release_p = wr_hit && (reg_sel == REG_STATUS) &&
                         avs.avs_s0_writedata[STAT_RELEASE_BIT];
      assign ovf_clr   = wr_hit && (reg_sel == REG_STATUS) &&
                         avs.avs_s0_writedata[STAT_OVF_BIT];

      // Control registers; BASE/STRIDE are locked while the channel runs.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ctrl_q <= '0;
        end else if (wr_hit) begin
          case (reg_sel)
            REG_BASE: begin
              if (!ctrl_q.en) ctrl_q.base <= MAX_ADDR_W'(avs.avs_s0_writedata[ADDR_W-1:0]);
            end
            REG_STRIDE: begin
              if (!ctrl_q.en) ctrl_q.stride <= MAX_ADDR_W'(avs.avs_s0_writedata[ADDR_W-1:0]);
            end
            REG_CTRL: begin
              ctrl_q.en      <= avs.avs_s0_writedata[CTRL_EN_BIT];
`ifdef DMA_ADDR_RING_IRQ_EN
              ctrl_q.irq_en  <= avs.avs_s0_writedata[CTRL_IRQ_EN_BIT];
`else
              ctrl_q.irq_en  <= 1'b0;
`endif
              ctrl_q.nbuf_m1 <= MAX_NBUF_W'(avs.avs_s0_writedata[CTRL_NBUF_LSB +: NBUF_W]);
            end
            default: ;
          endcase
        end
      end

      dma_ring_ch #(
        .ADDR_W (ADDR_W),
        .NBUF_W (NBUF_W)
      ) u_ch (
        .clk        (clk),
        .reset_n    (reset_n),
        .ctrl_i     (ctrl_q),
        .start_i    (start),
        .release_i  (release_p),
        .ovf_clr_i  (ovf_clr),
        .buf_done_i (buf_done[gi]),
        .addr_o     (addr),
        .wr_idx_o   (wr_idx),
        .fill_o     (fill),
        .ovf_o      (ovf)
      );

      // Pack CTRL and STATUS read views; undefined bits read as zero.
      always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_EN_BIT]     = ctrl_q.en;
        ctrl_word[CTRL_IRQ_EN_BIT] = ctrl_q.irq_en;
        ctrl_word[CTRL_NBUF_LSB +: MAX_NBUF_W] = ctrl_q.nbuf_m1;
        status_word = '0;
        status_word[STAT_IDX_LSB +: NBUF_W]    = wr_idx;
        status_word[STAT_FILL_LSB +: NBUF_W+1] = fill;
        status_word[STAT_OVF_BIT]              = ovf;
      end

      assign rd_base[gi]   = ctrl_q.base;
      assign rd_stride[gi] = ctrl_q.stride;
      assign rd_ctrl[gi]   = ctrl_word;
      assign rd_status[gi] = status_word;
      assign dma_address[gi*ADDR_W +: ADDR_W] = addr;
`ifdef DMA_ADDR_RING_IRQ_EN
      assign irq_src[gi] = ctrl_q.irq_en && ((fill != '0) || ovf);
`endif
    end
  endgenerate

  // Read mux; a channel number beyond NUM_CH reads as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(ch_sel) == i) begin
        case (reg_sel)
          REG_BASE:   rd_word = rd_base[i];
          REG_STRIDE: rd_word = rd_stride[i];
          REG_CTRL:   rd_word = rd_ctrl[i];
          default:    rd_word = rd_status[i];
        endcase
      end
    end
  end

  // Read data register: loads on a read strobe, otherwise holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (avs.avs_s0_read) begin
      readdata_q <= rd_word;
    end
  end

  assign avs.avs_s0_readdata = readdata_q;

`ifdef DMA_ADDR_RING_IRQ_EN
  // Registered interrupt so it trails the ring state by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |irq_src;
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dma_addr_ring.sv
// Testbench for dma_addr_ring: directed register/ring scenarios plus a
// randomized phase, all checked against a behavioural model in which the
// buffer address is base + index*stride. Honours DMA_ADDR_RING_IRQ_EN.
module tb_dma_addr_ring;
  import dma_addr_pkg::*;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 28;
  localparam int NBUF_W = 4;
`ifdef DMA_ADDR_RING_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam logic [31:0] AMASK = 32'h0FFF_FFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NUM_CH-1:0] bd = '0;
  logic [NUM_CH*ADDR_W-1:0] dma_address;
  logic irq;

  dma_addr_ring_if #(.NUM_CH(NUM_CH)) avs_if ();

  dma_addr_ring #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .NBUF_W (NBUF_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .avs         (avs_if),
    .buf_done    (bd),
    .dma_address (dma_address),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model state.
  logic [31:0] m_base [NUM_CH];
  logic [31:0] m_stride [NUM_CH];
  logic [31:0] m_base_act [NUM_CH];
  logic [31:0] m_stride_act [NUM_CH];
  bit          m_en [NUM_CH];
  bit          m_irq_en [NUM_CH];
  int          m_nbuf [NUM_CH];
  int          m_idx [NUM_CH];
  int          m_fill [NUM_CH];
  bit          m_ovf [NUM_CH];
  logic [31:0] m_rd;
  bit          m_irq;

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_base[c] = '0; m_stride[c] = '0; m_base_act[c] = '0; m_stride_act[c] = '0;
      m_en[c] = 0; m_irq_en[c] = 0; m_nbuf[c] = 0; m_idx[c] = 0; m_fill[c] = 0; m_ovf[c] = 0;
    end
    m_rd = '0;
    m_irq = 0;
  endtask

  function automatic logic [ADDR_W-1:0] m_addr(input int c);
    logic [63:0] t;
    t = 64'(m_base_act[c]) + 64'(m_idx[c]) * 64'(m_stride_act[c]);
    return t[ADDR_W-1:0];
  endfunction

  function automatic logic [31:0] m_read(input int c, input int r);
    logic [31:0] v;
    v = '0;
    case (r)
      0: v = m_base[c];
      1: v = m_stride[c];
      2: begin v[0] = m_en[c]; v[1] = m_irq_en[c]; v[11:8] = 4'(m_nbuf[c]); end
      default: begin v[3:0] = 4'(m_idx[c]); v[12:8] = 5'(m_fill[c]); v[31] = m_ovf[c]; end
    endcase
    return v;
  endfunction

  // Advance the model across one clock edge using the inputs presented.
  task automatic model_step();
    int ch, r;
    logic [31:0] wd;
    bit irq_n, wr_st, rel, clr, done, newovf;
    ch = int'(avs_if.avs_s0_address[2]);
    r  = int'(avs_if.avs_s0_address[1:0]);
    wd = avs_if.avs_s0_writedata;
    irq_n = 0;
    for (int c = 0; c < NUM_CH; c++)
      if (m_irq_en[c] && (m_fill[c] != 0 || m_ovf[c])) irq_n = 1;
    if (avs_if.avs_s0_read) m_rd = m_read(ch, r);
    for (int c = 0; c < NUM_CH; c++) begin
      wr_st  = avs_if.avs_s0_write && ch == c && r == 3;
      rel    = wr_st && wd[0] && m_fill[c] != 0;
      clr    = wr_st && wd[31];
      done   = bd[c] && m_en[c];
      newovf = 0;
      if (done && (m_fill[c] < m_nbuf[c] + 1 || rel)) begin
        m_idx[c] = (m_idx[c] == m_nbuf[c]) ? 0 : (m_idx[c] + 1) % 16;
        if (!rel) m_fill[c]++;
      end else if (done) begin
        newovf = 1;
      end else if (rel) begin
        m_fill[c]--;
      end
      if (newovf) m_ovf[c] = 1;
      else if (clr) m_ovf[c] = 0;
    end
    if (avs_if.avs_s0_write) begin
      case (r)
        0: if (!m_en[ch]) m_base[ch] = wd & AMASK;
        1: if (!m_en[ch]) m_stride[ch] = wd & AMASK;
        2: begin
          if (wd[0] && !m_en[ch]) begin
            m_idx[ch] = 0; m_fill[ch] = 0; m_ovf[ch] = 0;
            m_base_act[ch] = m_base[ch]; m_stride_act[ch] = m_stride[ch];
          end
          m_en[ch] = wd[0];
          m_irq_en[ch] = IRQ_ON && wd[1];
          m_nbuf[ch] = int'(wd[11:8]);
        end
        default: ;
      endcase
    end
    m_irq = irq_n;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] dut_addr(input int c);
    return dma_address[c*ADDR_W +: ADDR_W];
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int c = 0; c < NUM_CH; c++)
        check($sformatf("dma_address[%0d]", c), 64'(dut_addr(c)), 64'(m_addr(c)));
      check("irq", 64'(irq), 64'(m_irq));
      check("readdata", 64'(avs_if.avs_s0_readdata), 64'(m_rd));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    bd = '0;
    avs_if.avs_s0_read = 1'b0;
    avs_if.avs_s0_write = 1'b0;
  endtask

  task automatic set_wr(input int c, input int r, input logic [31:0] d);
    avs_if.avs_s0_write = 1'b1;
    avs_if.avs_s0_address = 3'(c * 4 + r);
    avs_if.avs_s0_writedata = d;
  endtask

  task automatic set_rd(input int c, input int r);
    avs_if.avs_s0_read = 1'b1;
    avs_if.avs_s0_address = 3'(c * 4 + r);
  endtask

  task automatic wr(input int c, input int r, input logic [31:0] d);
    set_wr(c, r, d);
    cycle();
  endtask

  task automatic rd_expect(input string name, input int c, input int r, input logic [31:0] exp);
    set_rd(c, r);
    cycle();
    check(name, 64'(avs_if.avs_s0_readdata), 64'(exp));
  endtask

  initial begin
    logic [27:0] exp_a [4];
    logic [31:0] wd;
    int c, op, r;
    exp_a[0] = 28'h100_1000; exp_a[1] = 28'h100_2000;
    exp_a[2] = 28'h100_3000; exp_a[3] = 28'h100_0000;
    avs_if.avs_s0_read = 1'b0;
    avs_if.avs_s0_write = 1'b0;
    avs_if.avs_s0_address = '0;
    avs_if.avs_s0_writedata = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    check_en = 1'b1;

    // Reset state.
    check("reset dma_address", 64'(dma_address), 64'd0);
    check("reset irq", 64'(irq), 64'd0);
    for (int ci = 0; ci < 2; ci++)
      for (int ri = 0; ri < 4; ri++)
        rd_expect($sformatf("reset read ch%0d reg%0d", ci, ri), ci, ri, 32'h0);

    // ch0 setup and fill four buffers back to back.
    wr(0, REG_BASE, 32'h0100_0000);
    wr(0, REG_STRIDE, 32'h0000_1000);
    wr(0, REG_CTRL, 32'h0000_0301);
    for (int i = 0; i < 4; i++) begin
      bd = 2'b01;
      cycle();
      check($sformatf("fill addr %0d", i), 64'(dut_addr(0)), 64'(exp_a[i]));
    end
    rd_expect("status full", 0, REG_STATUS, 32'h0000_0400);

    // Overflow on a full ring, then W1C.
    bd = 2'b01;
    cycle();
    check("ovf addr held", 64'(dut_addr(0)), 64'h100_0000);
    rd_expect("status ovf", 0, REG_STATUS, 32'h8000_0400);
    wr(0, REG_STATUS, 32'h8000_0000);
    rd_expect("status ovf cleared", 0, REG_STATUS, 32'h0000_0400);

    // FILL=2, then buf_done with RELEASE in the same cycle.
    wr(0, REG_STATUS, 32'h1);
    wr(0, REG_STATUS, 32'h1);
    bd = 2'b01;
    set_wr(0, REG_STATUS, 32'h1);
    cycle();
    check("done+release addr", 64'(dut_addr(0)), 64'h100_1000);
    rd_expect("done+release status", 0, REG_STATUS, 32'h0000_0201);
    repeat (3) wr(0, REG_STATUS, 32'h1);
    rd_expect("release to empty", 0, REG_STATUS, 32'h0000_0001);

    // Interrupt on ch1 only.
    wr(1, REG_BASE, 32'h0200_0000);
    wr(1, REG_STRIDE, 32'h0000_0040);
    wr(1, REG_CTRL, 32'h0000_0103);
    bd = 2'b10;
    cycle();
    check("irq at t+1", 64'(irq), 64'd0);
    cycle();
    check("irq at t+2", 64'(irq), 64'(IRQ_ON));
    wr(1, REG_STATUS, 32'h1);
    cycle();
    check("irq after release", 64'(irq), 64'd0);
    bd = 2'b01;
    cycle();
    cycle();
    check("irq ch0 masked", 64'(irq), 64'd0);

    // BASE write while enabled is ignored.
    wr(0, REG_BASE, 32'h0234_5678);
    rd_expect("base locked", 0, REG_BASE, 32'h0100_0000);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      bd[0] = ($urandom_range(0, 9) < 4);
      bd[1] = ($urandom_range(0, 9) < 4);
      op = int'($urandom_range(0, 15));
      c  = int'($urandom_range(0, 1));
      if (op <= 3) begin
        set_rd(c, int'($urandom_range(0, 3)));
      end else if (op <= 6) begin
        wd = $urandom;
        wd[0] = ($urandom_range(0, 2) != 0);
        wd[31] = ($urandom_range(0, 3) == 0);
        set_wr(c, REG_STATUS, wd);
      end else if (op == 7) begin
        r = int'($urandom_range(0, 1));
        set_wr(c, r, $urandom);
      end else if (op == 8) begin
        wd = $urandom;
        wd[0] = ($urandom_range(0, 4) != 0);
        if (m_en[c] && wd[0]) wd[11:8] = 4'(m_nbuf[c]);
        set_wr(c, REG_CTRL, wd);
      end
      cycle();
    end

    // Mid-ring asynchronous reset.
    wr(0, REG_CTRL, 32'h0);
    wr(0, REG_BASE, 32'h0ABC_0000);
    wr(0, REG_STRIDE, 32'h0000_0010);
    wr(0, REG_CTRL, 32'h0000_0301);
    bd = 2'b01;
    cycle();
    check("pre-reset addr", 64'(dut_addr(0)), 64'hABC_0010);
    rd_expect("pre-reset base", 0, REG_BASE, 32'h0ABC_0000);
    #3;
    check_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async reset dma_address", 64'(dma_address), 64'd0);
    check("async reset irq", 64'(irq), 64'd0);
    check("async reset readdata", 64'(avs_if.avs_s0_readdata), 64'd0);
    m_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    check_en = 1'b1;
    rd_expect("post-reset ctrl", 0, REG_CTRL, 32'h0);
    rd_expect("post-reset base", 0, REG_BASE, 32'h0);
    cycle();

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
